// File: rtl/field_mux_pkg.sv
// Shared definitions for the field multiplexer: FSM state encoding and
// the width helpers used to size the field index.
package field_mux_pkg;

    // Controller states: nothing held, one indexed result held, or a
    // held word being stepped through field by field.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for n fields; a single-field word still needs one bit.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/field_select.sv
// Combinational field extractor: returns data[idx*FIELD_W +: FIELD_W],
// or zero with oob set when idx does not name a field of the word.
module field_select
    import field_mux_pkg::*;
#(
    parameter int   DATA_W  = 16,
    parameter int   FIELD_W = 1,
    localparam int  NUM_F   = DATA_W / FIELD_W,
    localparam int  SEL_W   = sel_width(NUM_F)
) (
    input  logic [DATA_W-1:0]  data,
    input  logic [SEL_W-1:0]   idx,
    output logic [FIELD_W-1:0] field,
    output logic               oob
);

    logic [FIELD_W-1:0] fields [NUM_F];

    // Slice the word into its fields once so the mux below is a plain select.
    for (genvar gi = 0; gi < NUM_F; gi++) begin : g_slice
        assign fields[gi] = data[gi*FIELD_W +: FIELD_W];
    end

    // Index decode; the one-bit-wider compare keeps the range test
    // meaningful when NUM_F is an exact power of two.
    always_comb begin
        field = '0;
        oob   = ({1'b0, idx} >= (SEL_W + 1)'(NUM_F));
        for (int f = 0; f < NUM_F; f++) begin
            if (idx == SEL_W'(f)) begin
                field = fields[f];
            end
        end
    end

endmodule

// File: rtl/field_mux_scan.sv
// Registered field multiplexer with valid/ready on both sides. Extracts one
// FIELD_W-bit field from a DATA_W-bit word, either by index (one result per
// word) or by scanning every field of the word in ascending order.
// Optional feature: define FIELD_MUX_PARITY_EN to add out_par, the XOR of
// out_field, registered and held together with it.
module field_mux_scan
    import field_mux_pkg::*;
#(
    parameter int   DATA_W  = 16,
    parameter int   FIELD_W = 1,
    localparam int  NUM_F   = DATA_W / FIELD_W,
    localparam int  SEL_W   = sel_width(NUM_F)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_scan,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic [SEL_W-1:0]   out_index,
    output logic               out_last,
`ifdef FIELD_MUX_PARITY_EN
    output logic               out_par,
`endif
    output logic               out_err
);

    state_t             state_reg;
    state_t             state_next;
    logic [DATA_W-1:0]  word_reg;
    logic [DATA_W-1:0]  word_next;
    logic [SEL_W-1:0]   index_reg;
    logic [SEL_W-1:0]   index_next;
    logic [FIELD_W-1:0] field_reg;
    logic               valid_reg;
    logic               valid_next;
    logic               last_reg;
    logic               last_next;
    logic               err_reg;
    logic               err_next;
`ifdef FIELD_MUX_PARITY_EN
    logic               par_reg;
`endif

    logic               accept;
    logic               out_hs;
    logic [FIELD_W-1:0] sel_field;
    logic               sel_oob;

    assign accept = in_valid && in_ready;
    assign out_hs = valid_reg && out_ready;

    // A new word may enter only when the result currently shown is being
    // retired this cycle (or nothing is shown at all).
    always_comb begin
        case (state_reg)
            ST_IDLE: in_ready = 1'b1;
            ST_ONE:  in_ready = out_ready;
            ST_SCAN: in_ready = out_ready && last_reg;
            default: in_ready = 1'b0;
        endcase
    end

    // Next word/index/state. Without an accept or an output handshake
    // everything holds, which is what keeps the outputs stable under
    // backpressure.
    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        index_next = index_reg;
        if (accept) begin
            word_next = in_data;
            if (in_scan) begin
                state_next = ST_SCAN;
                index_next = '0;
            end else begin
                state_next = ST_ONE;
                index_next = in_sel;
            end
        end else if (out_hs) begin
            if (state_reg == ST_SCAN && !last_reg) begin
                index_next = index_reg + SEL_W'(1);
            end else begin
                state_next = ST_IDLE;
            end
        end
        if (state_reg != ST_IDLE && state_reg != ST_ONE && state_reg != ST_SCAN) begin
            state_next = ST_IDLE;
        end
    end

    // The selector looks at the word and index that will be held after
    // this edge, so the field can be registered alongside them.
    field_select #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W)
    ) u_select (
        .data  (word_next),
        .idx   (index_next),
        .field (sel_field),
        .oob   (sel_oob)
    );

    // Output flags derived from where the FSM is heading; error only
    // applies to an indexed result, a scan never runs out of range.
    always_comb begin
        valid_next = (state_next != ST_IDLE);
        last_next  = (state_next == ST_ONE) ||
                     (state_next == ST_SCAN && index_next == SEL_W'(NUM_F - 1));
        err_next   = (state_next == ST_ONE) && sel_oob;
    end

    // State and registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            word_reg  <= '0;
            index_reg <= '0;
            field_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef FIELD_MUX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            index_reg <= index_next;
            field_reg <= sel_field;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
`ifdef FIELD_MUX_PARITY_EN
            par_reg   <= ^sel_field;
`endif
        end
    end

    assign out_valid = valid_reg;
    assign out_field = field_reg;
    assign out_index = index_reg;
    assign out_last  = last_reg;
    assign out_err   = err_reg;
`ifdef FIELD_MUX_PARITY_EN
    assign out_par   = par_reg;
`endif

endmodule
